// File: rtl/keyb_pkg.sv
// keyb_pkg: keypad button codes shared with keyb_decoder and the scanner state type.
package keyb_pkg;
  localparam logic [7:0] BTN_NONE = 8'h00;
  localparam logic [7:0] BTN_1    = 8'h88;
  localparam logic [7:0] BTN_2    = 8'h48;
  localparam logic [7:0] BTN_3    = 8'h28;
  localparam logic [7:0] BTN_PLUS = 8'h18;
  localparam logic [7:0] BTN_4    = 8'h84;
  localparam logic [7:0] BTN_5    = 8'h44;
  localparam logic [7:0] BTN_6    = 8'h24;
  localparam logic [7:0] BTN_MIN  = 8'h14;
  localparam logic [7:0] BTN_7    = 8'h82;
  localparam logic [7:0] BTN_8    = 8'h42;
  localparam logic [7:0] BTN_9    = 8'h22;
  localparam logic [7:0] BTN_0    = 8'h41;
  localparam logic [7:0] BTN_EQ   = 8'h11;

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} scan_state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction
endpackage

// File: rtl/keyb_sync.sv
// keyb_sync: two-flop synchronizer, flops reset high to match idle pulled-up inputs.
module keyb_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1, r_s2;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end

  assign o_q = r_s2;
endmodule

// File: rtl/keyb_scanner.sv
// keyb_scanner: 4x4 keypad row scan, frame-level hit detection and press/release debounce.
module keyb_scanner
  import keyb_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [7:0] btn_id,
  output logic       btn_valid
);
  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_SCANS);

  logic [DW-1:0] r_div;
  logic [1:0]    r_slot, r_nhit;
  logic [7:0]    r_code, r_cand, w_cand, r_btn, w_btn, w_hit, w_fc;
  logic [CW-1:0] r_cnt, w_cnt, w_inc;
  logic [3:0]    w_col_n, w_col, w_row;
  logic [2:0]    w_sum;
  logic          r_valid, w_accept, w_sample, w_frame_end;
  scan_state_t   r_state, w_state;

  keyb_sync #(.W(4)) u_sync (.clk(clk), .rst(rst), .i_d(col_n), .o_q(w_col_n));

  assign w_row       = 4'b1000 >> r_slot;
  assign row_n       = ~w_row;
  assign w_col       = ~w_col_n;
  assign w_sample    = r_div == DW'(SCAN_DIV - 1);
  assign w_frame_end = w_sample && r_slot == 2'd3;
  // Hit count saturates at 2: only "exactly one" matters for the frame code.
  assign w_sum       = {1'b0, r_nhit} + popcount4(w_col);
  assign w_hit       = r_code | (|w_col ? {w_col, w_row} : BTN_NONE);
  assign w_fc        = w_sum == 3'd1 ? w_hit : BTN_NONE;
  assign w_inc       = r_cnt == C_MAX ? r_cnt : r_cnt + 1'b1;
  assign btn_id      = r_btn;
  assign btn_valid   = r_valid;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_div  <= '0;
      r_slot <= '0;
      r_nhit <= '0;
      r_code <= '0;
    end else begin
      r_div <= w_sample ? '0 : r_div + 1'b1;
      if (w_sample) begin
        r_slot <= r_slot + 1'b1;
        r_nhit <= w_frame_end ? 2'd0 : (w_sum > 3'd1 ? 2'd2 : w_sum[1:0]);
        r_code <= w_frame_end ? BTN_NONE : w_hit;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_btn   <= BTN_NONE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cand  <= w_cand;
      r_cnt   <= w_cnt;
      r_btn   <= w_btn;
      r_valid <= w_accept;
    end

  always_comb begin
    w_state  = r_state;
    w_cand   = r_cand;
    w_cnt    = r_cnt;
    w_btn    = r_btn;
    w_accept = 1'b0;
    if (w_frame_end)
      case (r_state)
        S_IDLE:
          if (w_fc != BTN_NONE) begin
            w_cand   = w_fc;
            w_cnt    = CW'(1);
            w_accept = DEBOUNCE_SCANS == 1;
            w_state  = w_accept ? S_PRESSED : S_DEBOUNCE;
          end
        S_DEBOUNCE:
          if (w_fc == BTN_NONE) begin
            w_state = S_IDLE;
            w_cnt   = '0;
          end else if (w_fc == r_cand) begin
            w_cnt    = w_inc;
            w_accept = w_inc == C_MAX;
            w_state  = w_accept ? S_PRESSED : S_DEBOUNCE;
          end else begin
            w_cand = w_fc;
            w_cnt  = CW'(1);
          end
        S_PRESSED:
          if (w_fc == BTN_NONE) begin
            w_state = DEBOUNCE_SCANS == 1 ? S_IDLE : S_RELEASE;
            w_cnt   = CW'(1);
            w_btn   = DEBOUNCE_SCANS == 1 ? BTN_NONE : r_btn;
          end
        S_RELEASE:
          if (w_fc == BTN_NONE) begin
            w_cnt   = w_inc;
            w_state = w_inc == C_MAX ? S_IDLE : S_RELEASE;
            w_btn   = w_inc == C_MAX ? BTN_NONE : r_btn;
          end else
            w_state = S_PRESSED;
        default: w_state = S_IDLE;
      endcase
    if (w_accept) w_btn = w_cand;
  end
endmodule

// File: tb/tb_keyb_scanner.sv
// tb_keyb_scanner: directed test-plan scenarios plus random key traffic against a frame-level keypad model.
module tb_keyb_scanner;
  import keyb_pkg::*;
  localparam int DS = 3;
  localparam int M_IDLE = 0, M_DEB = 1, M_PRS = 2, M_REL = 3;

  logic       clk = 1'b0, rst = 1'b0;
  logic [3:0] col_n, row_n;
  logic [7:0] btn_id;
  logic       btn_valid;
  logic [15:0] keys = '0;
  int n_assert = 0, n_fail = 0, cyc = 0, v_cnt = 0, v_first = -1;

  logic [3:0] col_q[$];
  logic [7:0] hits[$];
  int         m_state, m_cnt;
  logic [7:0] m_cand, m_btn;
  logic       m_valid;

  always #5 clk = ~clk;

  keyb_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n), .btn_id(btn_id), .btn_valid(btn_valid)
  );

  // Passive keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  function automatic logic [15:0] key(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    col_q.delete();
    hits.delete();
    m_state = M_IDLE;
    m_cnt   = 0;
    m_cand  = 8'h00;
    m_btn   = 8'h00;
    m_valid = 1'b0;
  endtask

  task automatic accept();
    m_state = M_PRS;
    m_btn   = m_cand;
    m_valid = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] fc);
    case (m_state)
      M_IDLE: if (fc != 0) begin
        m_cand = fc; m_cnt = 1;
        if (DS == 1) accept(); else m_state = M_DEB;
      end
      M_DEB: if (fc == 0) m_state = M_IDLE;
        else if (fc == m_cand) begin m_cnt++; if (m_cnt >= DS) accept(); end
        else begin m_cand = fc; m_cnt = 1; end
      M_PRS: if (fc == 0) begin
        if (DS == 1) begin m_state = M_IDLE; m_btn = 0; end
        else begin m_state = M_REL; m_cnt = 1; end
      end
      default: if (fc == 0) begin
        m_cnt++;
        if (m_cnt >= DS) begin m_state = M_IDLE; m_btn = 0; end
      end else m_state = M_PRS;
    endcase
  endtask

  // Edge n since reset: row slot (n/4)%4, sample on n%4==3 sees col_n from two edges earlier.
  task automatic model_edge();
    int n;
    logic [3:0] smp, rowoh;
    if (rst) begin model_reset(); return; end
    n = col_q.size() - 1;
    m_valid = 1'b0;
    if (n % 4 == 3) begin
      smp   = col_q[n-2];
      rowoh = 4'b1000 >> ((n / 4) % 4);
      for (int c = 0; c < 4; c++)
        if (!smp[c]) hits.push_back(8'(1 << (c + 4)) | {4'b0, rowoh});
    end
    if (n % 16 == 15) begin
      model_frame(hits.size() == 1 ? hits[0] : 8'h00);
      hits.delete();
    end
  endtask

  task automatic tick();
    logic [3:0] er;
    @(negedge clk);
    col_q.push_back(col_n);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    er = ~(4'b1000 >> ((col_q.size() / 4) % 4));
    check("btn_id", btn_id, m_btn);
    check("btn_valid", 8'(btn_valid), 8'(m_valid));
    check("row_n", 8'(row_n), 8'(er));
    if (btn_valid === 1'b1) begin
      v_cnt++;
      if (v_first < 0) v_first = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic mark();
    cyc = 0; v_cnt = 0; v_first = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_row_n", 8'(row_n), 8'h07);
    check("rst_btn_id", btn_id, 8'h00);
    check("rst_btn_valid", 8'(btn_valid), 8'h00);
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rs[4];
    int sel;
    rs = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    model_reset();
    #2;
    do_reset();
    run(22);
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i % 4 == 0) check("row_seq", 8'(row_n), 8'(rs[(i / 4) % 4]));
    end

    mark(); keys = key(2, 2);
    run(80);
    check("k5_strobes", 8'(v_cnt), 8'd1);
    check("k5_latency", 8'(v_first >= 32 && v_first <= 67), 8'd1);
    check("k5_id", btn_id, BTN_5);
    keys = '0;
    run(32);
    check("k5_hold", btn_id, 8'h44);
    run(40);
    check("k5_release", btn_id, 8'h00);
    check("k5_single", 8'(v_cnt), 8'd1);

    mark(); keys = key(3, 3);
    run(32);
    keys = '0;
    run(64);
    check("bounce_strobes", 8'(v_cnt), 8'd0);
    check("bounce_id", btn_id, 8'h00);
    check("bounce_idle", 8'(dut.r_state), 8'(S_IDLE));

    mark(); keys = key(3, 3) | key(3, 2);
    run(80);
    check("multi_strobes", 8'(v_cnt), 8'd0);
    check("multi_id", btn_id, 8'h00);
    keys = key(3, 3);
    run(80);
    check("multi_rel_strobes", 8'(v_cnt), 8'd1);
    check("multi_rel_id", btn_id, BTN_1);
    keys = '0;
    run(80);

    mark(); keys = key(0, 0);
    run(80);
    check("eq_id", btn_id, 8'h11);
    keys = '0;
    run(16);
    keys = key(0, 0);
    run(32);
    check("relb_id", btn_id, 8'h11);
    check("relb_strobes", 8'(v_cnt), 8'd1);
    keys = '0;
    run(80);
    check("relb_final", btn_id, 8'h00);
    check("relb_single", 8'(v_cnt), 8'd1);

    mark(); keys = key(1, 1);
    run(32);
    do_reset();
    check("rstdeb_strobes", 8'(v_cnt), 8'd0);
    run(80);
    check("rstdeb_after", 8'(v_cnt), 8'd1);
    check("rstdeb_id", btn_id, BTN_9);
    keys = '0;
    run(80);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom % 4);
      keys = sel == 0 ? 16'h0 :
             sel == 2 ? (key(0, 0) << ($urandom % 16)) | (key(0, 0) << ($urandom % 16)) :
                        key(0, 0) << ($urandom % 16);
      if ($urandom % 12 == 0) do_reset();
      run(int'($urandom_range(1, 90)));
    end
    keys = '0;
    run(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
